// File: rtl/seq_mul_ctrl_if.sv
// Host-side handshake bundle for the sequential multiplier: operands and start
// in, product register and busy/done status out.
interface seq_mul_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   Out;
    logic                 busy;
    logic                 done;

    modport master (output start, output A, output B,
                    input  Out,   input  busy, input done);
    modport slave  (input  start, input  A, input  B,
                    output Out,   output busy, output done);
endinterface

// File: rtl/seq_mul_ctrl.sv
// Shift-and-add multiplier: one 2*WIDTH-bit adder reused over WIDTH RUN cycles,
// sequenced by an IDLE/RUN/DONE FSM with registered busy/done/Out.
module seq_mul_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_mul_ctrl_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   out_q;
    logic            busy_q;
    logic            done_q;

    // Accumulator value after this cycle's conditional add.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // FSM, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            out_q    <= {PW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // DONE also accepts start so results can stream back-to-back.
                    if (bus.start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.A};
                        mplier_q <= bus.B;
                        acc_q    <= {PW{1'b0}};
                        cnt_q    <= {CW{1'b0}};
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        out_q   <= acc_d;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench: WIDTH=4 instance for directed/random/corner sequences,
// WIDTH=2 instance for an exhaustive sweep against plain multiplication.
module tb_seq_mul_ctrl;
    logic clk;
    logic rst;

    seq_mul_ctrl_if #(.WIDTH(4)) m4 ();
    seq_mul_ctrl_if #(.WIDTH(2)) m2 ();

    seq_mul_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(m4));
    seq_mul_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(m2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    int exp_out4;
    int exp_out2;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         p;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 multiply; operands scrambled during RUN to prove capture.
    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input int p);
        @(negedge clk);
        m4.start = 1'b1;
        m4.A = a;
        m4.B = b;
        step();
        m4.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("mul4 busy", int'(m4.busy), 1);
            check("mul4 done_early", int'(m4.done), 0);
            check("mul4 out_hold", int'(m4.Out), exp_out4);
            m4.A = 4'($urandom);
            m4.B = 4'($urandom);
            step();
        end
        exp_out4 = p;
        check("mul4 done", int'(m4.done), 1);
        check("mul4 busy_in_done", int'(m4.busy), 0);
        check("mul4 out", int'(m4.Out), exp_out4);
        step();
        check("mul4 done_once", int'(m4.done), 0);
        check("mul4 out_after", int'(m4.Out), exp_out4);
    endtask

    task automatic mul2(input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        m2.start = 1'b1;
        m2.A = a;
        m2.B = b;
        step();
        m2.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("mul2 busy", int'(m2.busy), 1);
            check("mul2 done_early", int'(m2.done), 0);
            m2.A = 2'($urandom);
            m2.B = 2'($urandom);
            step();
        end
        exp_out2 = int'(a) * int'(b);
        check("mul2 done", int'(m2.done), 1);
        check("mul2 out", int'(m2.Out), exp_out2);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        m4.start = 1'b0; m4.A = 4'd0; m4.B = 4'd0;
        m2.start = 1'b0; m2.A = 2'd0; m2.B = 2'd0;
        tbl[0] = '{a: 4'd3,  b: 4'd5,  p: 15};
        tbl[1] = '{a: 4'd15, b: 4'd15, p: 225};
        tbl[2] = '{a: 4'd0,  b: 4'd9,  p: 0};
        tbl[3] = '{a: 4'd1,  b: 4'd0,  p: 0};
        tbl[4] = '{a: 4'd8,  b: 4'd12, p: 96};

        step(); step();
        rst = 1'b0;
        exp_out4 = 0;
        exp_out2 = 0;
        check("reset out", int'(m4.Out), 0);
        check("reset busy", int'(m4.busy), 0);
        check("reset done", int'(m4.done), 0);
        step();
        check("idle busy", int'(m4.busy), 0);

        for (int i = 0; i < 5; i++) begin
            mul4(tbl[i].a, tbl[i].b, tbl[i].p);
        end

        for (int i = 0; i < 20; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            mul4(ra, rb, int'(ra) * int'(rb));
        end

        // Start held high: a result every 5 cycles, A/B scrambled while running.
        @(negedge clk);
        m4.start = 1'b1; m4.A = 4'd6; m4.B = 4'd7;
        for (int c = 0; c < 15; c++) begin
            step();
            if (c == 4) exp_out4 = 42;
            check("hold busy", int'(m4.busy), (c % 5 != 4) ? 1 : 0);
            check("hold done", int'(m4.done), (c % 5 == 4) ? 1 : 0);
            check("hold out", int'(m4.Out), exp_out4);
            if (c % 5 == 4) begin
                m4.A = 4'd6; m4.B = 4'd7;
            end else begin
                m4.A = 4'($urandom); m4.B = 4'($urandom);
            end
        end
        m4.start = 1'b0;
        step();
        check("hold idle busy", int'(m4.busy), 0);
        check("hold idle done", int'(m4.done), 0);

        // start during RUN is ignored and not queued.
        @(negedge clk);
        m4.start = 1'b1; m4.A = 4'd2; m4.B = 4'd3;
        step();
        m4.start = 1'b0;
        @(negedge clk);
        m4.start = 1'b1; m4.A = 4'd9; m4.B = 4'd9;
        step();
        m4.start = 1'b0;
        step(); step(); step();
        exp_out4 = 6;
        check("ignore done", int'(m4.done), 1);
        check("ignore out", int'(m4.Out), 6);
        for (int c = 0; c < 6; c++) begin
            step();
            check("ignore no_second_done", int'(m4.done), 0);
            check("ignore idle busy", int'(m4.busy), 0);
            check("ignore out_hold", int'(m4.Out), 6);
        end

        // Reset on the 2nd RUN cycle aborts with no done pulse.
        @(negedge clk);
        m4.start = 1'b1; m4.A = 4'd5; m4.B = 4'd5;
        step();
        m4.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_out4 = 0;
        check("abort busy", int'(m4.busy), 0);
        check("abort done", int'(m4.done), 0);
        check("abort out", int'(m4.Out), 0);
        for (int c = 0; c < 6; c++) begin
            step();
            check("abort no_done", int'(m4.done), 0);
            check("abort out_hold", int'(m4.Out), 0);
        end
        mul4(4'd4, 4'd4, 16);

        // Simultaneous start and reset: reset wins, start dropped.
        @(negedge clk);
        m4.start = 1'b1; m4.A = 4'd7; m4.B = 4'd3;
        rst = 1'b1;
        step();
        m4.start = 1'b0;
        rst = 1'b0;
        exp_out4 = 0;
        check("rst_start busy", int'(m4.busy), 0);
        check("rst_start out", int'(m4.Out), 0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("rst_start no_done", int'(m4.done), 0);
        end

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                mul2(2'(a), 2'(b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_mul_ctrl.md
# seq_mul_ctrl

Sequential shift-and-add multiplier: one adder is reused over WIDTH clock cycles to form a 2·WIDTH-bit product, replacing a full combinational array for wider operands. A small FSM sequences the datapath. It exposes a start/busy/done handshake so a host can issue multiplications one at a time. With WIDTH=2, each result must match the combinational 2-bit multiplier (A·B to a 4-bit Out).

## Interface
- WIDTH, 4: operand width in bits, ≥2; product is 2·WIDTH bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled on rising edge.
- A  in  WIDTH  multiplicand (unsigned), captured when start is accepted.
- B  in  WIDTH  multiplier (unsigned), captured when start is accepted.
- Out  out  2·WIDTH  product register; holds last completed result.
- busy  out  1  high while a multiply is in progress (RUN state).
- done  out  1  one-cycle pulse: Out has just been updated.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - mcand: 2·WIDTH bits, the zero-extended A.
  - mplier: WIDTH bits, a copy of B.
  - acc: 2·WIDTH bits, the running sum.
  - cnt: ⌈log2(WIDTH+1)⌉ bits, the step counter.
- IDLE or DONE, start=1: capture mcand←{0,A}, mplier←B, acc←0, cnt←0, go to RUN. Start is accepted in DONE so back-to-back operations are possible.
- IDLE, start=0: stay in IDLE. DONE, start=0: go to IDLE.
- RUN, each cycle:
  - If mplier[0]=1, acc←acc+mcand. All addition is 2·WIDTH bits and unsigned; it cannot overflow.
  - mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1.
- RUN, when cnt=WIDTH−1: perform the final step, load Out←final acc value (including this step's add), go to DONE.
- start while in RUN is ignored. Operands do not change and no request is queued.
- No early termination: zero or small operands still take exactly WIDTH RUN cycles.
- A and B are don't-care except on the accepting edge.
- Out changes only on entry to DONE and on reset. It holds its value through IDLE and through the next RUN.

## Timing
- Reset values: Out=0, busy=0, done=0; state=IDLE; acc, mcand, mplier and cnt cleared.
- rst has priority over everything. Asserting rst during RUN aborts the operation: next cycle is IDLE, Out=0, and no done pulse is produced.
- Let edge 0 be the edge where start is accepted.
  - busy=1 during the cycles after edges 0 … WIDTH−1.
  - The edge WIDTH transition loads Out and enters DONE.
  - done=1 for exactly the one cycle after edge WIDTH; busy=0 in that cycle.
- Latency: WIDTH+1 cycles from start sampled to done visible.
- Throughput: one result per WIDTH+1 cycles when start is held high or re-asserted in DONE.
- done and busy are never high in the same cycle. done is never high for two consecutive cycles.
- busy and done are registered (Moore) outputs with no combinational path from start.
- Simultaneous start and rst: rst wins and start is dropped.

## Test plan
- WIDTH=4, reset, then start with A=3, B=5 → busy for 4 cycles; Out=15 with done pulse at latency 5; Out stays 15 afterwards.
- WIDTH=4, A=15, B=15 → Out=225. Then A=0, B=9 → Out=0, still after exactly 5 cycles with the done pulse.
- WIDTH=4, A=6, B=7 with start held high continuously → results 42, 42, … with a done pulse every 5 cycles. Change A/B during RUN and check the in-flight result is unaffected.
- WIDTH=4, A=2, B=3 accepted; pulse start again with A=9, B=9 mid-RUN → that start is ignored, Out=6, no second done pulse.
- WIDTH=4, A=5, B=5 accepted; assert rst on the 2nd RUN cycle → next cycle is IDLE with Out=0, busy=0 and no done pulse. A fresh start with A=4, B=4 → Out=16.
- WIDTH=2, exhaustive sweep of all 16 A/B pairs → every Out equals A·B, matching the combinational 2-bit multiplier; latency is 3 cycles each.
